// File: rtl/ysyx_23060240_core_ctrl.sv
// rtl/ysyx_23060240_core_ctrl.sv - multi-cycle fetch/execute/memory/writeback sequencer for the NPC core
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   inst_req_*        fetch request handshake to the IFU
//   inst_rsp_*        fetched instruction return
//   inst_reg          latched current instruction (to IMM/decoder)
//   lsu_req_*         load/store request handshake (we: 1=store, 0=load)
//   lsu_rsp_valid     load data / store completion
//   rf_we, pc_we      writeback strobes
//   halt, err         sticky terminal status (ebreak / illegal opcode or bus timeout)
//   instret           retired instruction count
module ysyx_23060240_core_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    input  logic        inst_rsp_valid,
    input  logic [31:0] inst_rsp_data,
    output logic [31:0] inst_reg,
    output logic        lsu_req_valid,
    output logic        lsu_req_we,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halt,
    output logic        err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        IF_REQ   = 3'd0,
        IF_WAIT  = 3'd1,
        EX       = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6,
        ERR      = 3'd7
    } state_t;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    // The watchdog value during the last permitted cycle of a wait state.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd;
    logic             capture;
    logic             wd_state;
    logic             timeout;
    logic [6:0]       opcode;
    logic             is_mem;
    logic             is_wb_op;

    assign opcode = inst_reg[6:0];
    assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

    always_comb begin
        is_wb_op = 1'b0;
        case (opcode)
            7'b0010111, 7'b0110111, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0010011, 7'b0110011, 7'b1110011: is_wb_op = 1'b1;
            default:                                        is_wb_op = 1'b0;
        endcase
    end

    assign wd_state = (state == IF_REQ) || (state == IF_WAIT) ||
                      (state == MEM_REQ) || (state == MEM_WAIT);
    assign timeout  = wd_state && (wd == WD_LAST);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IF_REQ:   if (inst_req_ready) state_nxt = IF_WAIT;
            IF_WAIT:  if (inst_rsp_valid) begin
                          state_nxt = EX;
                          capture   = 1'b1;
                      end
            EX:       begin
                          // ebreak shares the SYSTEM opcode, so it must be matched first.
                          if (inst_reg == EBREAK) state_nxt = HALT;
                          else if (is_mem)        state_nxt = MEM_REQ;
                          else if (is_wb_op)      state_nxt = WB;
                          else                    state_nxt = ERR;
                      end
            MEM_REQ:  if (lsu_req_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (lsu_rsp_valid) state_nxt = WB;
            WB:       state_nxt = IF_REQ;
            HALT:     state_nxt = HALT;
            ERR:      state_nxt = ERR;
            default:  state_nxt = ERR;
        endcase
        // A handshake finishing on the last allowed cycle wins over the timeout.
        if (timeout && (state_nxt == state)) state_nxt = ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_REQ;
            inst_reg <= 32'd0;
            instret  <= 32'd0;
            wd       <= '0;
        end else begin
            state <= state_nxt;
            if (capture) inst_reg <= inst_rsp_data;
            if (state == WB) instret <= instret + 32'd1;
            if (wd_state && (state_nxt == state)) wd <= wd + 1'b1;
            else                                  wd <= '0;
        end
    end

    // Strobes are decoded from the registered state and forced low during reset.
    assign inst_req_valid = !rst && (state == IF_REQ);
    assign lsu_req_valid  = !rst && (state == MEM_REQ);
    assign lsu_req_we     = !rst && (state == MEM_REQ) && (opcode == OP_STORE);
    assign rf_we          = !rst && (state == WB) && (opcode != OP_BRANCH) && (opcode != OP_STORE);
    assign pc_we          = !rst && (state == WB);
    assign halt           = !rst && (state == HALT);
    assign err            = !rst && (state == ERR);

endmodule

// File: tb/tb_ysyx_23060240_core_ctrl.sv
// tb/tb_ysyx_23060240_core_ctrl.sv - directed self-checking bench for ysyx_23060240_core_ctrl
module tb_ysyx_23060240_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic        inst_rsp_valid;
    logic [31:0] inst_rsp_data;
    logic [31:0] inst_reg;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        rf_we;
    logic        pc_we;
    logic        halt;
    logic        err;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060240_core_ctrl #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_rsp_valid (inst_rsp_valid),
        .inst_rsp_data  (inst_rsp_data),
        .inst_reg       (inst_reg),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_we     (lsu_req_we),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_rsp_valid  (lsu_rsp_valid),
        .rf_we          (rf_we),
        .pc_we          (pc_we),
        .halt           (halt),
        .err            (err),
        .instret        (instret)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // From IF_REQ with inst_req_ready=1: request, one-cycle response; ends in EX.
    task automatic do_fetch(input logic [31:0] data);
        tick();
        inst_rsp_valid = 1'b1;
        inst_rsp_data  = data;
        tick();
        inst_rsp_valid = 1'b0;
        inst_rsp_data  = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (inst_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", inst_req_valid); end
        checks++; if (inst_reg !== 32'd0) begin errors++; $display("FAIL reset_inst_reg got=%h exp=0", inst_reg); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        checks++; if ({halt, err, rf_we, pc_we, lsu_req_valid} !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=00000", {halt, err, rf_we, pc_we, lsu_req_valid}); end
        rst = 1'b0;
        #1;
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL reset_exit_req got=%b exp=1", inst_req_valid); end
    endtask

    task automatic test_alu;
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL alu_c1_req got=%b exp=1", inst_req_valid); end
        tick();
        checks++; if (inst_req_valid !== 1'b0) begin errors++; $display("FAIL alu_c2_req got=%b exp=0", inst_req_valid); end
        inst_rsp_valid = 1'b1;
        inst_rsp_data  = 32'h0050_0093;
        tick();
        inst_rsp_valid = 1'b0;
        checks++; if (inst_reg !== 32'h0050_0093) begin errors++; $display("FAIL alu_inst_reg got=%h exp=00500093", inst_reg); end
        checks++; if ({rf_we, pc_we} !== 2'b00) begin errors++; $display("FAIL alu_ex_strobes got=%b exp=00", {rf_we, pc_we}); end
        tick();
        checks++; if ({rf_we, pc_we} !== 2'b11) begin errors++; $display("FAIL alu_wb_strobes got=%b exp=11", {rf_we, pc_we}); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL alu_wb_instret got=%0d exp=0", instret); end
        tick();
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL alu_instret got=%0d exp=1", instret); end
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL alu_period got=%b exp=1", inst_req_valid); end
    endtask

    task automatic test_store_load;
        logic [31:0] insts [2];
        insts[0] = 32'h0011_2023;
        insts[1] = 32'h0001_2103;
        for (int i = 0; i < 2; i++) begin
            do_fetch(insts[i]);
            tick();
            checks++; if (lsu_req_valid !== 1'b1) begin errors++; $display("FAIL mem%0d_req_valid got=%b exp=1", i, lsu_req_valid); end
            checks++; if (lsu_req_we !== (i == 0)) begin errors++; $display("FAIL mem%0d_we got=%b exp=%b", i, lsu_req_we, (i == 0)); end
            tick();
            checks++; if (lsu_req_valid !== 1'b0) begin errors++; $display("FAIL mem%0d_wait_valid got=%b exp=0", i, lsu_req_valid); end
            lsu_rsp_valid = 1'b1;
            tick();
            lsu_rsp_valid = 1'b0;
            checks++; if ({rf_we, pc_we} !== {(i == 1), 1'b1}) begin errors++; $display("FAIL mem%0d_wb got=%b exp=%b1", i, {rf_we, pc_we}, (i == 1)); end
            tick();
            checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL mem%0d_period got=%b exp=1", i, inst_req_valid); end
        end
        checks++; if (instret !== 32'd3) begin errors++; $display("FAIL mem_instret got=%0d exp=3", instret); end
    endtask

    task automatic test_branch_stall;
        inst_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL br_stall%0d_req got=%b exp=1", i, inst_req_valid); end
            tick();
        end
        inst_req_ready = 1'b1;
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL br_stall3_req got=%b exp=1", inst_req_valid); end
        do_fetch(32'h0000_0463);
        tick();
        checks++; if ({rf_we, pc_we} !== 2'b01) begin errors++; $display("FAIL br_wb got=%b exp=01", {rf_we, pc_we}); end
        tick();
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL br_instret got=%0d exp=4", instret); end
    endtask

    task automatic test_halt;
        do_fetch(32'h0010_0073);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({halt, err, inst_req_valid, pc_we, rf_we} !== 5'b10000) begin errors++; $display("FAIL halt%0d got=%b exp=10000", i, {halt, err, inst_req_valid, pc_we, rf_we}); end
            tick();
        end
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL halt_instret got=%0d exp=4", instret); end
        checks++; if (inst_reg !== 32'h0010_0073) begin errors++; $display("FAIL halt_inst_reg got=%h exp=00100073", inst_reg); end
    endtask

    task automatic test_illegal;
        apply_reset();
        do_fetch(32'h0000_007F);
        tick();
        tick();
        checks++; if ({err, halt, inst_req_valid, lsu_req_valid} !== 4'b1000) begin errors++; $display("FAIL illegal got=%b exp=1000", {err, halt, inst_req_valid, lsu_req_valid}); end
        checks++; if (inst_reg !== 32'h0000_007F) begin errors++; $display("FAIL illegal_inst_reg got=%h exp=0000007f", inst_reg); end
    endtask

    task automatic test_timeout;
        apply_reset();
        do_fetch(32'h0001_2103);
        tick();
        tick();
        // Now in MEM_WAIT, cycle 0; the 255th cycle is index 254.
        repeat (254) tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", err); end
        tick();
        checks++; if ({err, rf_we, pc_we} !== 3'b100) begin errors++; $display("FAIL timeout_err got=%b exp=100", {err, rf_we, pc_we}); end
    endtask

    task automatic test_timeout_handshake;
        apply_reset();
        do_fetch(32'h0001_2103);
        tick();
        tick();
        repeat (254) tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        checks++; if ({err, rf_we, pc_we} !== 3'b011) begin errors++; $display("FAIL to_hs_wb got=%b exp=011", {err, rf_we, pc_we}); end
        tick();
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL to_hs_instret got=%0d exp=1", instret); end
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL to_hs_req got=%b exp=1", inst_req_valid); end
    endtask

    task automatic test_reset_mid;
        do_fetch(32'h0001_2103);
        tick();
        tick();
        lsu_rsp_valid = 1'b1;
        rst = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
        checks++; if (inst_reg !== 32'd0) begin errors++; $display("FAIL rmid_inst_reg got=%h exp=0", inst_reg); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rmid_instret got=%0d exp=0", instret); end
        checks++; if ({inst_req_valid, rf_we, pc_we} !== 3'b000) begin errors++; $display("FAIL rmid_strobes got=%b exp=000", {inst_req_valid, rf_we, pc_we}); end
        rst = 1'b0;
        #1;
        checks++; if (inst_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", inst_req_valid); end
    endtask

    initial begin
        rst            = 1'b1;
        inst_req_ready = 1'b1;
        inst_rsp_valid = 1'b0;
        inst_rsp_data  = 32'd0;
        lsu_req_ready  = 1'b1;
        lsu_rsp_valid  = 1'b0;
        test_reset();
        test_alu();
        test_store_load();
        test_branch_stall();
        test_halt();
        test_illegal();
        test_timeout();
        test_timeout_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
